// File: rtl/mips_debug_dump_unit_if.sv
// Debug request/response bundle between the MicroBlaze debug interface
// (master) and the dump unit (slave).
interface mips_debug_dump_unit_if #(
  parameter int NB_REG = 32
);
  logic [5:0]        i_request_select;
  logic [NB_REG-1:0] o_frame;
  logic              o_eod;
  logic              o_busy;

  modport master (
    output i_request_select,
    input  o_frame,
    input  o_eod,
    input  o_busy
  );

  modport slave (
    input  i_request_select,
    output o_frame,
    output o_eod,
    output o_busy
  );
endinterface

// File: rtl/mips_debug_dump_unit.sv
// Decodes a debug request code, snapshots the addressed source and streams it
// out as 32-bit frames, one per clock, closed by a one-cycle EoD strobe.
module mips_debug_dump_unit #(
  parameter int NB_REG   = 32,
  parameter int N_WORDS  = 3,
  parameter int NB_LATCH = N_WORDS * NB_REG
) (
  input  logic                i_clock,
  input  logic                i_reset,
  mips_debug_dump_unit_if.slave dbg,
  output logic [4:0]          o_reg_read_addr,
  input  logic [NB_REG-1:0]   i_reg_read_data,
  input  logic [NB_REG-1:0]   i_pc,
  input  logic [NB_REG-1:0]   i_data_mem_rd_data,
  input  logic [NB_REG-1:0]   i_instr_mem_rd_data,
  input  logic [NB_LATCH-1:0] i_fetch_data,
  input  logic [NB_LATCH-1:0] i_deco_data,
  input  logic [NB_LATCH-1:0] i_exec_data,
  input  logic [NB_LATCH-1:0] i_mem_data,
  input  logic [NB_REG-1:0]   i_fetch_ctrl,
  input  logic [NB_REG-1:0]   i_deco_ctrl,
  input  logic [NB_REG-1:0]   i_exec_ctrl,
  input  logic [NB_REG-1:0]   i_mem_ctrl
);
  localparam int NB_LEN = $clog2(N_WORDS + 1);
  localparam logic [5:0] CODE_IDLE = 6'h3F;
  localparam logic [5:0] CODE_DMEM = 6'h20;
  localparam logic [5:0] CODE_IMEM = 6'h21;

  typedef enum logic [1:0] {IDLE, SEND, EOD} state_t;

  state_t             r_state, w_next_state;
  logic [5:0]         r_code;
  logic [NB_LEN-1:0]  r_len, r_idx, w_len;
  logic [NB_REG-1:0]  r_words [N_WORDS];
  logic [NB_LATCH-1:0] w_snap;
  logic               w_req;

  // Single-word sources occupy word 0, which is the MS slot of the buffer.
  function automatic logic [NB_LATCH-1:0] as_word0(input logic [NB_REG-1:0] x);
    return {x, {(NB_LATCH-NB_REG){1'b0}}};
  endfunction

  assign o_reg_read_addr = dbg.i_request_select[4:0];
  assign w_req           = (dbg.i_request_select != CODE_IDLE);

  always_comb begin
    w_len  = '0;
    w_snap = '0;
    if (!dbg.i_request_select[5]) begin
      w_len  = NB_LEN'(1);
      w_snap = as_word0(i_reg_read_data);
    end else begin
      case (dbg.i_request_select)
        CODE_DMEM, CODE_IMEM: w_len = NB_LEN'(1);
        6'h22: begin w_len = NB_LEN'(1);       w_snap = as_word0(i_pc);         end
        6'h24: begin w_len = NB_LEN'(N_WORDS); w_snap = i_fetch_data;           end
        6'h25: begin w_len = NB_LEN'(1);       w_snap = as_word0(i_fetch_ctrl); end
        6'h26: begin w_len = NB_LEN'(N_WORDS); w_snap = i_deco_data;            end
        6'h27: begin w_len = NB_LEN'(1);       w_snap = as_word0(i_deco_ctrl);  end
        6'h28: begin w_len = NB_LEN'(N_WORDS); w_snap = i_exec_data;            end
        6'h29: begin w_len = NB_LEN'(1);       w_snap = as_word0(i_exec_ctrl);  end
        6'h2A: begin w_len = NB_LEN'(N_WORDS); w_snap = i_mem_data;             end
        6'h2B: begin w_len = NB_LEN'(1);       w_snap = as_word0(i_mem_ctrl);   end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_req) w_next_state = (w_len != '0) ? SEND : EOD;
      SEND: if (r_idx == NB_LEN'(r_len - NB_LEN'(1))) w_next_state = EOD;
      EOD:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_code  <= CODE_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      for (int k = 0; k < N_WORDS; k++) r_words[k] <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        IDLE: if (w_req) begin
          r_code <= dbg.i_request_select;
          r_len  <= w_len;
          r_idx  <= '0;
          for (int k = 0; k < N_WORDS; k++)
            r_words[k] <= w_snap[NB_LATCH-1-k*NB_REG -: NB_REG];
        end
        SEND: r_idx <= r_idx + NB_LEN'(1);
        default: ;
      endcase
    end
  end

  // Memory words bypass the snapshot: the memories answer one cycle after
  // the request, which is exactly the single SEND cycle.
  always_comb begin
    dbg.o_frame = '0;
    if (r_state == SEND) begin
      if (r_code == CODE_DMEM)      dbg.o_frame = i_data_mem_rd_data;
      else if (r_code == CODE_IMEM) dbg.o_frame = i_instr_mem_rd_data;
      else                          dbg.o_frame = r_words[r_idx];
    end
  end

  assign dbg.o_eod  = (r_state == EOD);
  assign dbg.o_busy = (r_state != IDLE);
endmodule
